// File: rtl/dma_pkg.sv
// Shared definitions for the DMA read prefetcher.
//   - default ADDR_W / DATA_W / LEN_W / DEPTH values
//   - DRAM read latency, in cycles from o_dram_rd_en to i_dram_rd_valid
//   - control FSM state encoding
package dma_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;
    localparam int DEPTH_DEF  = 4;

    // The credit logic tracks exactly one cycle of DRAM latency
    // (exp_valid_q in dma_rd_prefetch).
    localparam int RD_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with an occupancy count.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_push            write i_push_data
//                     (a push into a full FIFO is dropped unless a pop
//                     happens in the same cycle)
//   i_pop             drop the head entry (ignored when empty)
//   o_head            current head entry, 0 when empty
//   o_valid           FIFO non-empty
//   o_count           current occupancy, 0..DEPTH
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign o_valid = (o_count != '0);
    assign do_pop  = i_pop && o_valid;
    assign do_push = i_push && ((o_count != CNT_W'(DEPTH)) || do_pop);

    // Head is forced to 0 while empty so the output is clean after reset.
    assign o_head = o_valid ? mem[rd_ptr] : '0;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   o_count <= o_count + CNT_W'(1);
                2'b01:   o_count <= o_count - CNT_W'(1);
                default: o_count <= o_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/dma_rd_prefetch.sv
// Read-side DMA front end.
// Ports:
//   i_clk, i_rst                          clock, asynchronous active-high reset
//   i_req_start                           one-cycle request strobe
//   i_req_base_addr, i_req_len            first byte address, byte count (0 ok)
//   o_req_busy                            transfer in progress
//   o_req_done                            one-cycle pulse after the last byte is consumed
//   o_dram_rd_en, o_dram_rd_addr          single-byte DRAM read request
//   i_dram_rd_data, i_dram_rd_valid       DRAM response, one cycle after the request
//   o_data, o_data_valid, i_data_ready    show-ahead output stream
//   o_fifo_count                          buffer occupancy
//   o_err                                 sticky: unexpected DRAM data, or start while busy
//
// State table
//   state | meaning
//   IDLE  | no transfer; a start with len>0 issues the first read right away
//   ISSUE | reads still to issue, gated by FIFO credit
//   DRAIN | all reads issued, waiting for the consumer to take the rest
module dma_rd_prefetch
    import dma_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req_start,
    input  logic [ADDR_W-1:0]        i_req_base_addr,
    input  logic [LEN_W-1:0]         i_req_len,
    output logic                     o_req_busy,
    output logic                     o_req_done,
    output logic                     o_dram_rd_en,
    output logic [ADDR_W-1:0]        o_dram_rd_addr,
    input  logic [DATA_W-1:0]        i_dram_rd_data,
    input  logic                     i_dram_rd_valid,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_data_valid,
    input  logic                     i_data_ready,
    output logic [$clog2(DEPTH):0]   o_fifo_count,
    output logic                     o_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  issue_cnt;
    logic [LEN_W-1:0]  out_cnt;
    logic              exp_valid_q;
    logic              pop;
    logic [OCC_W-1:0]  occ;
    logic              credit_ok;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (i_dram_rd_valid),
        .i_push_data (i_dram_rd_data),
        .i_pop       (i_data_ready),
        .o_head      (o_data),
        .o_valid     (o_data_valid),
        .o_count     (o_fifo_count)
    );

    assign pop = o_data_valid && i_data_ready;

    // Occupancy once everything already requested has landed: the buffer,
    // the read on the bus this cycle, and the response arriving this cycle.
    // A pop this cycle frees a slot, which is what sustains one byte per
    // cycle. Issuing another read is allowed only if the total stays
    // within DEPTH-1.
    assign occ = OCC_W'(o_fifo_count) + OCC_W'(o_dram_rd_en)
               + OCC_W'(exp_valid_q) - OCC_W'(pop);
    assign credit_ok = (occ < OCC_W'(DEPTH - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= IDLE;
            addr_q         <= '0;
            issue_cnt      <= '0;
            out_cnt        <= '0;
            exp_valid_q    <= 1'b0;
            o_req_busy     <= 1'b0;
            o_req_done     <= 1'b0;
            o_dram_rd_en   <= 1'b0;
            o_dram_rd_addr <= '0;
            o_err          <= 1'b0;
        end else begin
            o_req_done  <= 1'b0;
            exp_valid_q <= o_dram_rd_en;

            if (i_dram_rd_valid && !exp_valid_q) o_err <= 1'b1;
            if (i_req_start && state != IDLE)    o_err <= 1'b1;

            case (state)
                IDLE: begin
                    o_dram_rd_en <= 1'b0;
                    if (i_req_start) begin
                        if (i_req_len == '0) begin
                            o_req_done <= 1'b1;
                        end else begin
                            // The first read goes out at the same edge, so
                            // issue_cnt holds the reads still to issue.
                            o_req_busy     <= 1'b1;
                            o_dram_rd_en   <= 1'b1;
                            o_dram_rd_addr <= i_req_base_addr;
                            addr_q         <= i_req_base_addr + ADDR_W'(1);
                            issue_cnt      <= i_req_len - LEN_W'(1);
                            out_cnt        <= i_req_len;
                            state          <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_cnt != '0 && credit_ok) begin
                        o_dram_rd_en   <= 1'b1;
                        o_dram_rd_addr <= addr_q;
                        addr_q         <= addr_q + ADDR_W'(1);
                        issue_cnt      <= issue_cnt - LEN_W'(1);
                    end else begin
                        o_dram_rd_en <= 1'b0;
                    end
                    if (issue_cnt == '0) state <= DRAIN;
                end
                DRAIN: begin
                    o_dram_rd_en <= 1'b0;
                end
                default: begin
                    o_dram_rd_en <= 1'b0;
                    state        <= IDLE;
                end
            endcase

            // Completion overrides the state update above.
            if (state != IDLE && pop) begin
                out_cnt <= out_cnt - LEN_W'(1);
                if (out_cnt == LEN_W'(1)) begin
                    o_req_done   <= 1'b1;
                    o_req_busy   <= 1'b0;
                    o_dram_rd_en <= 1'b0;
                    state        <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_rd_prefetch.sv
module tb_dma_rd_prefetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] base;
    logic [7:0] len;
    logic       busy, done;
    logic       rd_en;
    logic [9:0] rd_addr;
    logic [7:0] dram_data = 8'h00;
    logic       dram_valid = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       ready;
    logic [2:0] fifo_count;
    logic       err;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int snap;

    logic [9:0] exp_addr[$];
    logic [7:0] exp_data[$];

    always #5 clk = ~clk;

    dma_rd_prefetch #(.ADDR_W(10), .DATA_W(8), .LEN_W(8), .DEPTH(4)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_req_start     (start),
        .i_req_base_addr (base),
        .i_req_len       (len),
        .o_req_busy      (busy),
        .o_req_done      (done),
        .o_dram_rd_en    (rd_en),
        .o_dram_rd_addr  (rd_addr),
        .i_dram_rd_data  (dram_data),
        .i_dram_rd_valid (dram_valid),
        .o_data          (data),
        .o_data_valid    (data_valid),
        .i_data_ready    (ready),
        .o_fifo_count    (fifo_count),
        .o_err           (err)
    );

    // DRAM contents: a fixed function of the address.
    function automatic logic [7:0] dram_byte(input logic [9:0] a);
        int v;
        v = int'(a) * 37 + 11;
        return v[7:0];
    endfunction

    // DRAM model: fixed one-cycle latency, no backpressure.
    always @(posedge clk) begin
        dram_valid <= rd_en;
        dram_data  <= dram_byte(rd_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [9:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            logic [9:0] a;
            a = b + 10'(i);
            exp_addr.push_back(a);
            exp_data.push_back(dram_byte(a));
        end
    endtask

    task automatic do_start(input logic [9:0] b, input logic [7:0] l);
        base  = b;
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done pulse within %0d cycles", limit);
        end else begin
            chk("busy_at_done", busy, 0);
            tick();
            chk("done_single_pulse", done, 0);
        end
    endtask

    task automatic chk_drained(input string name);
        chk({name, "_addr_q_empty"}, exp_addr.size(), 0);
        chk({name, "_data_q_empty"}, exp_data.size(), 0);
    endtask

    // Monitor: compares every issued address and every consumed byte
    // against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en) begin
                rd_cnt++;
                if (exp_addr.size() == 0) chk("unexpected_rd_en", 1, 0);
                else chk("rd_addr", rd_addr, exp_addr.pop_front());
            end
            if (data_valid && ready) begin
                if (exp_data.size() == 0) chk("unexpected_data", 1, 0);
                else chk("o_data", data, exp_data.pop_front());
            end
        end
    end

    // A push into a full FIFO without a simultaneous pop must never happen.
    always @(posedge clk) begin
        if (!rst && dram_valid && fifo_count == 3'd4 && !(data_valid && ready)) begin
            errors++;
            $display("FAIL fifo_overflow: push with count %0d", fifo_count);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        base  = '0;
        len   = '0;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_err", err, 0);
        chk("rst_data", data, 0);
        rst = 1'b0;
        tick();

        // base=5 len=3: latency T+1 rd_en, T+3 data valid
        push_exp(10'd5, 3);
        do_start(10'd5, 8'd3);
        chk("t1_rd_en_T1", rd_en, 1);
        chk("t1_rd_addr_T1", rd_addr, 5);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_data_valid_T2", data_valid, 0);
        tick();
        chk("t1_data_valid_T3", data_valid, 1);
        wait_done(50);
        chk_drained("t1");

        // address wrap 1022,1023,0,1
        push_exp(10'd1022, 4);
        do_start(10'd1022, 8'd4);
        wait_done(50);
        chk("t2_err", err, 0);
        chk_drained("t2");

        // consumer stalled: only DEPTH-1 reads outstanding
        ready = 1'b0;
        snap  = rd_cnt;
        push_exp(10'd100, 10);
        do_start(10'd100, 8'd10);
        repeat (10) tick();
        chk("t3_reads_while_stalled", rd_cnt - snap, 3);
        chk("t3_fifo_count", fifo_count, 3);
        chk("t3_data_valid", data_valid, 1);
        chk("t3_busy", busy, 1);
        ready = 1'b1;
        wait_done(60);
        chk("t3_total_reads", rd_cnt - snap, 10);
        chk_drained("t3");

        // len=0
        snap = rd_cnt;
        do_start(10'd50, 8'd0);
        chk("t4_done_T1", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_rd_en", rd_en, 0);
        tick();
        chk("t4_done_T2", done, 0);
        chk("t4_busy_T2", busy, 0);
        chk("t4_no_reads", rd_cnt - snap, 0);

        // start while busy is ignored and sets sticky err
        push_exp(10'd200, 4);
        do_start(10'd200, 8'd4);
        tick();
        do_start(10'd300, 8'd6);
        chk("t5_err_set", err, 1);
        wait_done(50);
        chk("t5_err_sticky", err, 1);
        chk_drained("t5");
        tick();
        chk("t5_err_still", err, 1);

        // reset mid-transfer with 2 bytes buffered
        ready = 1'b0;
        push_exp(10'd400, 10);
        do_start(10'd400, 8'd10);
        begin
            int n;
            n = 0;
            while (fifo_count != 3'd2 && n < 20) begin
                tick();
                n++;
            end
            chk("t6_two_buffered", fifo_count, 2);
        end
        chk("t6_busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_rd_en", rd_en, 0);
        chk("t6_rst_rd_addr", rd_addr, 0);
        chk("t6_rst_data_valid", data_valid, 0);
        chk("t6_rst_fifo_count", fifo_count, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_data", data, 0);
        exp_addr.delete();
        exp_data.delete();
        repeat (3) tick();
        rst   = 1'b0;
        ready = 1'b1;
        tick();
        chk("t6_err_after_release", err, 0);
        push_exp(10'd10, 2);
        do_start(10'd10, 8'd2);
        wait_done(50);
        chk("t6_err_final", err, 0);
        chk_drained("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
